// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, constants and encoder helpers for request_arbiter
package arb_pkg;

  localparam int NREQ = 7;
  localparam int IDXW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // 7:3 priority encoder: highest set index wins, 0 when nothing is set.
  function automatic logic [IDXW-1:0] prio_enc(input logic [NREQ:1] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  // Folds 1..14 back into the 1..7 requester range.
  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW:0] x);
    return (x > 4'd7) ? IDXW'(x - 4'd7) : x[IDXW-1:0];
  endfunction

  function automatic logic [NREQ:1] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ:1] v;
    v = '0;
    for (int i = 1; i <= NREQ; i++) begin
      v[i] = (idx == IDXW'(i));
    end
    return v;
  endfunction

endpackage

// File: rtl/request_arbiter_if.sv
// rtl/request_arbiter_if.sv - requester-side handshake bundle for request_arbiter
interface request_arbiter_if;
  import arb_pkg::*;

  logic [NREQ:1]   req;
  logic            rel;
  logic            mode;
  logic [NREQ:1]   gnt;
  logic [IDXW-1:0] gidx;
  logic            busy;
  logic            timeout;

  modport master (
    output req, rel, mode,
    input  gnt, gidx, busy, timeout
  );

  modport slave (
    input  req, rel, mode,
    output gnt, gidx, busy, timeout
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner select, fixed priority or round-robin
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ:1]   req,
  input  logic [IDXW-1:0] last,
  input  logic            mode,
  output logic [IDXW-1:0] win
);

  logic [NREQ:1]   rot;
  logic [IDXW-1:0] rot_win;

  // Rotated so that last+1 lands on bit 7: the highest-first encoder then
  // yields the first requester in round-robin order.
  always_comb begin
    rot = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rot[NREQ + 1 - k] = req[wrap_idx({1'b0, last} + 4'(k))];
    end
    rot_win = prio_enc(rot);
    win     = '0;
    if (!mode) begin
      win = prio_enc(req);
    end else if (rot_win != '0) begin
      win = wrap_idx({1'b0, last} + (4'd8 - {1'b0, rot_win}));
    end
  end

endmodule

// File: rtl/request_arbiter.sv
// rtl/request_arbiter.sv - seven-way grant-holding arbiter with hold timeout
module request_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAXHOLD = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  request_arbiter_if.slave  bus
);

  arb_state_t      state_q, state_d;
  logic [NREQ:1]   gnt_q, gnt_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      holdcnt_q, holdcnt_d;
  logic [IDXW-1:0] last_q, last_d;

  logic [IDXW-1:0] win;
  logic            hold_hit;
  logic            grant_exit;

  rr_pick u_rr_pick (
    .req  (bus.req),
    .last (last_q),
    .mode (bus.mode),
    .win  (win)
  );

  assign hold_hit   = (holdcnt_q == 8'(MAXHOLD));
  assign grant_exit = bus.rel || !bus.req[gidx_q] || hold_hit;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    holdcnt_d = holdcnt_q;
    last_d    = last_q;
    case (state_q)
      GRANT: begin
        if (grant_exit) begin
          state_d   = GAP;
          gnt_d     = '0;
          gidx_d    = '0;
          busy_d    = 1'b0;
          holdcnt_d = '0;
          // A release on the last allowed cycle is an orderly exit, not a timeout.
          timeout_d = hold_hit && !bus.rel;
        end else if (holdcnt_q != 8'hFF) begin
          holdcnt_d = holdcnt_q + 8'd1;
        end
      end
      default: begin
        if (bus.req != '0) begin
          state_d   = GRANT;
          gnt_d     = onehot(win);
          gidx_d    = win;
          busy_d    = 1'b1;
          last_d    = win;
          holdcnt_d = 8'd1;
        end else begin
          state_d   = IDLE;
          gnt_d     = '0;
          gidx_d    = '0;
          busy_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      holdcnt_q <= '0;
      last_q    <= 3'd7;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      holdcnt_q <= holdcnt_d;
      last_q    <= last_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gidx    = gidx_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_request_arbiter.sv
// tb/tb_request_arbiter.sv - directed-vector bench for request_arbiter (MAXHOLD=4)
module tb_request_arbiter;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_miss;

  request_arbiter_if bus ();

  request_arbiter #(.MAXHOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] g, input logic [7:0] gi,
                            input logic b, input logic t);
    check({tag, ".gnt"}, {1'b0, bus.gnt}, g);
    check({tag, ".gidx"}, {5'd0, bus.gidx}, gi);
    check({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, b});
    check({tag, ".timeout"}, {7'd0, bus.timeout}, {7'd0, t});
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    reset_n   = 1'b0;
    bus.req   = 7'b1111111;
    bus.rel   = 1'b0;
    bus.mode  = 1'b0;

    tick();
    check_outs("rst_c1", 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    check_outs("rst_c2", 8'h00, 8'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    check_outs("rst_rel", 8'h40, 8'd7, 1'b1, 1'b0);

    // Requesters 2,3,5; grantee 7 drops, so a GAP precedes grant to 5.
    bus.req = 7'b0010110;
    tick();
    check_outs("fp_gap0", 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    check_outs("fp_win", 8'h10, 8'd5, 1'b1, 1'b0);
    bus.rel = 1'b1;
    tick();
    check_outs("fp_relgap", 8'h00, 8'd0, 1'b0, 1'b0);
    bus.rel = 1'b0;
    tick();
    check_outs("fp_regrant", 8'h10, 8'd5, 1'b1, 1'b0);
    bus.req = '0;
    tick();
    tick();
    check_outs("idle", 8'h00, 8'd0, 1'b0, 1'b0);

    // Hold timeout with req[3] alone.
    bus.req = 7'b0000100;
    tick();
    check_outs("to_g1", 8'h04, 8'd3, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("to_busy%0d", i), {7'd0, bus.busy}, 8'd1);
    end
    tick();
    check_outs("to_pulse", 8'h00, 8'd0, 1'b0, 1'b1);
    tick();
    check_outs("to_regrant", 8'h04, 8'd3, 1'b1, 1'b0);
    // Release coinciding with the hold limit must not flag timeout.
    tick();
    tick();
    tick();
    bus.rel = 1'b1;
    tick();
    check_outs("to_rel", 8'h00, 8'd0, 1'b0, 1'b0);
    bus.rel = 1'b0;
    bus.req = '0;
    tick();

    // Grantee 6 drops its request while 2 waits.
    bus.req = 7'b0100010;
    tick();
    check_outs("drop_g6", 8'h20, 8'd6, 1'b1, 1'b0);
    tick();
    check("drop_hold6", {5'd0, bus.gidx}, 8'd6);
    bus.req = 7'b0000010;
    tick();
    check_outs("drop_gap", 8'h00, 8'd0, 1'b0, 1'b0);
    tick();
    check_outs("drop_g2", 8'h02, 8'd2, 1'b1, 1'b0);
    bus.req = '0;

    // Round-robin from a fresh reset: 1,0,2,0,...,7,0,1.
    reset_n = 1'b0;
    tick();
    reset_n  = 1'b1;
    bus.mode = 1'b1;
    bus.req  = 7'b1111111;
    bus.rel  = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      tick();
      check($sformatf("rr_seq%0d", i), {5'd0, bus.gidx},
            (i % 2 == 1) ? 8'd0 : 8'((i / 2) % 7 + 1));
    end

    // Mid-grant reset while 4 holds the grant.
    bus.rel  = 1'b0;
    bus.mode = 1'b0;
    bus.req  = 7'b0001000;
    tick();
    tick();
    check_outs("mr_g4", 8'h08, 8'd4, 1'b1, 1'b0);
    reset_n = 1'b0;
    tick();
    check_outs("mr_rst", 8'h00, 8'd0, 1'b0, 1'b0);
    reset_n  = 1'b1;
    bus.mode = 1'b1;
    bus.req  = 7'b1111111;
    tick();
    check_outs("mr_rr1", 8'h01, 8'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
